usb_frame_ctrl: RTL and testbench
=================================

# usb_frame_ctrl

Frame-level controller for the USB video ingest path. It hunts for a two-byte start-of-frame marker in the raw USB byte stream and gates the frame's payload bytes into the 24-bit pixel packer. It turns the packer's pixel strobes into linear frame-buffer write addresses and reports frame completion, aborts and the active double-buffer bank. It sits between the USB receive interface and the frame-buffer write port, with the packer in the loop.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, write address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- SYNC0, 8'hA5, first start-of-frame byte
- SYNC1, 8'h5A, second start-of-frame byte
- TIMEOUT, 65535, idle cycles between payload bytes before abort (>= 2)
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-low reset
- usb_byte  in  8  raw byte from the USB receiver
- usb_byte_valid  in  1  usb_byte qualifier, one cycle per byte
- pk_byte  out  8  byte forwarded to the packer
- pk_byte_valid  out  1  pk_byte qualifier
- pk_clr  out  1  one-cycle pulse that resynchronises the packer byte phase
- pix_data  in  24  packed pixel from the packer
- pix_valid  in  1  pix_data qualifier
- wr_addr  out  ADDR_W  frame-buffer write address
- wr_data  out  24  frame-buffer write data
- wr_en  out  1  frame-buffer write strobe
- buf_sel  out  1  bank being written; the display reads !buf_sel
- frame_done  out  1  one-cycle pulse, frame complete
- frame_err  out  1  one-cycle pulse, frame aborted on timeout
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, SYNC, RECV, DONE.
- IDLE
  - Valid byte == SYNC0 -> SYNC.
  - All other bytes are dropped.
- SYNC, on each valid byte:
  - == SYNC1 -> RECV; pk_clr pulses the following cycle.
  - == SYNC0 -> stay in SYNC.
  - Any other value -> IDLE.
- Sync bytes are never forwarded.
- RECV, forwarding
  - Each valid byte is forwarded while the payload byte count < 3*H_ACTIVE*V_ACTIVE.
  - Bytes beyond that count are dropped.
  - The byte counter and pixel counter both clear on entry to RECV.
- RECV, writes
  - Each pix_valid produces a write: wr_data = pix_data, wr_addr = pixel count.
  - The pixel count increments by 1 per pix_valid; there is no gap at line boundaries, so address = y*H_ACTIVE + x.
  - The pixel count does not wrap within a frame.
- RECV, exits
  - pix_valid while the pixel count == H_ACTIVE*V_ACTIVE-1 -> DONE.
  - Timeout counter clears on every valid byte and increments otherwise. Reaching TIMEOUT -> IDLE, frame_err pulses, buf_sel is unchanged.
  - Timeout is checked only in RECV.
- DONE: lasts exactly one cycle, then -> IDLE. buf_sel toggles on DONE exit.
- pix_valid outside RECV is ignored: no write is issued.
- Byte and pix_valid in the same cycle: both are processed independently.
- Timeout expiry in the same cycle as the final pix_valid: completion wins; no frame_err.

## Timing
- All outputs are registered.
- Reset (rst_n low at a clk edge) values:
  - state IDLE; all counters 0
  - pk_byte, pk_byte_valid, pk_clr = 0
  - wr_addr, wr_data, wr_en = 0
  - buf_sel, frame_done, frame_err, busy = 0
- Reset asserted mid-frame: everything returns to the reset values at the next edge. No frame_done or frame_err is produced.
- Byte forwarding: usb_byte at cycle t appears on pk_byte/pk_byte_valid at t+1.
- pk_clr: SYNC1 accepted at cycle t -> pk_clr high at t+1, which precedes the first forwarded payload byte.
- Write: pix_valid at cycle t -> wr_en/wr_addr/wr_data at t+1.
- Completion: final pix_valid at cycle t -> the last wr_en (addr H_ACTIVE*V_ACTIVE-1) and frame_done are both high at t+1; buf_sel toggles at t+2.
- Abort: last byte at cycle t with no further bytes -> frame_err high at t+TIMEOUT+1.
- busy rises the cycle after SYNC0 is accepted and falls the cycle after DONE, or after the abort.

## Test plan
- Reset: drive random inputs with rst_n low -> all outputs 0; first frame after release writes to bank 0.
- Nominal frame, H_ACTIVE=4, V_ACTIVE=2, with a behavioural packer: A5 5A then 24 payload bytes ->
  - pk_clr exactly once.
  - 24 forwarded bytes.
  - 8 writes, addresses 0..7, data matching the packer order.
  - frame_done coincident with the write to addr 7.
  - buf_sel 0->1.
- Marker hunting: stream 00 A5 00 A5 A5 5A then payload -> only the final A5 5A opens the frame; 00 after A5 returns to IDLE; no sync byte is forwarded.
- Overrun: 30 payload bytes into a 24-byte frame -> exactly 24 bytes forwarded; the 6 extra bytes are dropped; a following A5 5A starts a new frame at addr 0 with buf_sel 1->0.
- Timeout, TIMEOUT=16: 10 payload bytes then silence -> frame_err 17 cycles after the last byte; busy low; buf_sel unchanged; the next frame restarts at addr 0 with pk_clr.
- Mid-frame reset: rst_n low for 1 cycle after pixel 3 -> outputs at reset values, no frame_done or frame_err, and a new frame after sync writes from addr 0.

Source files
------------

// File: rtl/usb_frame_ctrl.sv
// USB video ingest frame controller: hunts the two-byte start-of-frame marker,
// gates payload bytes into the pixel packer and turns pixel strobes into frame-buffer writes.
module usb_frame_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned ADDR_W   = 19,
  parameter logic [7:0]  SYNC0    = 8'hA5,
  parameter logic [7:0]  SYNC1    = 8'h5A,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        usb_byte,
  input  logic              usb_byte_valid,
  output logic [7:0]        pk_byte,
  output logic              pk_byte_valid,
  output logic              pk_clr,
  input  logic [23:0]       pix_data,
  input  logic              pix_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_en,
  output logic              buf_sel,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned NPIX   = H_ACTIVE * V_ACTIVE;
  localparam int unsigned NBYTES = 3 * NPIX;
  localparam int unsigned BCNT_W = $clog2(NBYTES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [BCNT_W-1:0] BYTE_MAX = BCNT_W'(NBYTES);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(NPIX - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RECV,
    DONE
  } state_t;

  state_t              r_state;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic [ADDR_W-1:0]   r_pix_cnt;
  logic [TMO_W-1:0]    r_tmo_cnt;

  logic w_byte_room;
  logic w_last_pix;
  logic w_tmo_hit;

  assign w_byte_room = (r_byte_cnt < BYTE_MAX);
  assign w_last_pix  = pix_valid && (r_pix_cnt == PIX_LAST);
  // Expiry needs an idle cycle; a byte arriving on the boundary cycle still restarts the count.
  assign w_tmo_hit   = !usb_byte_valid && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_byte_cnt    <= '0;
      r_pix_cnt     <= '0;
      r_tmo_cnt     <= '0;
      pk_byte       <= '0;
      pk_byte_valid <= 1'b0;
      pk_clr        <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_en         <= 1'b0;
      buf_sel       <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      pk_byte_valid <= 1'b0;
      pk_clr        <= 1'b0;
      wr_en         <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;

      case (r_state)
        IDLE: begin
          if (usb_byte_valid && (usb_byte == SYNC0)) begin
            r_state <= SYNC;
            busy    <= 1'b1;
          end
        end

        SYNC: begin
          if (usb_byte_valid) begin
            if (usb_byte == SYNC1) begin
              r_state    <= RECV;
              pk_clr     <= 1'b1;
              r_byte_cnt <= '0;
              r_pix_cnt  <= '0;
              r_tmo_cnt  <= '0;
            end else if (usb_byte != SYNC0) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        end

        RECV: begin
          if (usb_byte_valid) begin
            r_tmo_cnt <= '0;
            if (w_byte_room) begin
              pk_byte       <= usb_byte;
              pk_byte_valid <= 1'b1;
              r_byte_cnt    <= r_byte_cnt + BCNT_W'(1);
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          end

          if (pix_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= r_pix_cnt;
            wr_data <= pix_data;
          end

          // Completion takes priority over a coincident timeout.
          if (w_last_pix) begin
            r_state    <= DONE;
            frame_done <= 1'b1;
          end else begin
            if (pix_valid) begin
              r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
            end
            if (w_tmo_hit) begin
              r_state   <= IDLE;
              frame_err <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          buf_sel <= ~buf_sel;
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_frame_ctrl.sv
// Directed bench for usb_frame_ctrl on a 4x2 frame with a behavioural 3-byte packer.
module tb_usb_frame_ctrl;

  localparam int unsigned H   = 4;
  localparam int unsigned V   = 2;
  localparam int unsigned AW  = 3;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    usb_byte;
  logic          usb_byte_valid;
  logic [7:0]    pk_byte;
  logic          pk_byte_valid;
  logic          pk_clr;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          wr_en;
  logic          buf_sel;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  logic          m_pv;
  logic [23:0]   m_pd;
  logic [1:0]    m_ph;
  logic [7:0]    m_b0;
  logic [7:0]    m_b1;
  logic          rnd_pv;
  logic [23:0]   rnd_pd;

  assign pix_valid = m_pv | rnd_pv;
  assign pix_data  = rnd_pv ? rnd_pd : m_pd;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int clr_n = 0;
  int done_n = 0;
  int err_n = 0;
  int last_fwd_cyc = 0;
  int err_cyc = 0;
  logic [7:0]    fwd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [23:0]   wd_q[$];
  logic          done_wen = 1'b0;
  logic          done_bsel = 1'b0;
  logic [AW-1:0] done_addr = '0;

  usb_frame_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .ADDR_W  (AW),
    .SYNC0   (8'hA5),
    .SYNC1   (8'h5A),
    .TIMEOUT (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .usb_byte      (usb_byte),
    .usb_byte_valid(usb_byte_valid),
    .pk_byte       (pk_byte),
    .pk_byte_valid (pk_byte_valid),
    .pk_clr        (pk_clr),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .buf_sel       (buf_sel),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Packer: first byte of each triple lands in the MSBs.
  always @(posedge clk) begin
    m_pv <= 1'b0;
    if (!rst_n || pk_clr) begin
      m_ph <= 2'd0;
    end else if (pk_byte_valid) begin
      if (m_ph == 2'd2) begin
        m_pv <= 1'b1;
        m_pd <= {m_b0, m_b1, pk_byte};
        m_ph <= 2'd0;
      end else begin
        if (m_ph == 2'd0) m_b0 <= pk_byte;
        else              m_b1 <= pk_byte;
        m_ph <= m_ph + 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (pk_clr) clr_n = clr_n + 1;
    if (pk_byte_valid) begin
      fwd_q.push_back(pk_byte);
      last_fwd_cyc = cyc;
    end
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (frame_done) begin
      done_n    = done_n + 1;
      done_wen  = wr_en;
      done_addr = wr_addr;
      done_bsel = buf_sel;
    end
    if (frame_err) begin
      err_n   = err_n + 1;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({pk_byte, pk_byte_valid, pk_clr, wr_addr, wr_data, wr_en,
                buf_sel, frame_done, frame_err, busy});
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    usb_byte       = b;
    usb_byte_valid = 1'b1;
    @(posedge clk);
    #2;
    usb_byte_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) send_byte(base + 8'(i));
  endtask

  task automatic send_frame(input logic [7:0] base, input int n);
    send_byte(8'hA5);
    send_byte(8'h5A);
    send_payload(base, n);
  endtask

  task automatic chk_pixels(input string tag, input int ws, input logic [7:0] base, input int npx);
    logic [7:0] b;
    for (int i = 0; i < npx; i++) begin
      b = base + 8'(3 * i);
      chk($sformatf("%s_addr%0d", tag, i), 64'(wa_q[ws + i]), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wd_q[ws + i]), 64'({b, b + 8'd1, b + 8'd2}));
    end
  endtask

  task automatic chk_fwd(input string tag, input int fs, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_fwd%0d", tag, i), 64'(fwd_q[fs + i]), 64'(base + 8'(i)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, w, c, d, e;
    rst_n          = 1'b0;
    usb_byte       = '0;
    usb_byte_valid = 1'b0;
    rnd_pv         = 1'b0;
    rnd_pd         = '0;

    // Random activity under reset
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #2;
      usb_byte       = 8'($urandom);
      usb_byte_valid = 1'($urandom);
      rnd_pv         = 1'($urandom);
      rnd_pd         = 24'($urandom);
    end
    idle(1);
    chk("reset_outs", all_outs(), 64'd0);

    // Strobes in IDLE must not write or start a frame
    rst_n          = 1'b1;
    rnd_pv         = 1'b1;
    usb_byte       = 8'h5A;
    usb_byte_valid = 1'b1;
    idle(3);
    rnd_pv         = 1'b0;
    usb_byte_valid = 1'b0;
    idle(1);
    chk("idle_writes", 64'(wa_q.size()), 64'd0);
    chk("idle_fwd", 64'(fwd_q.size()), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Nominal frame
    f = fwd_q.size(); w = wa_q.size(); c = clr_n; d = done_n; e = err_n;
    send_byte(8'hA5);
    chk("nom_busy_sync", 64'(busy), 64'd1);
    send_byte(8'h5A);
    chk("nom_pk_clr", 64'(pk_clr), 64'd1);
    send_payload(8'h10, 24);
    idle(10);
    chk("nom_clr_cnt", 64'(clr_n - c), 64'd1);
    chk("nom_fwd_cnt", 64'(fwd_q.size() - f), 64'd24);
    chk_fwd("nom", f, 8'h10, 24);
    chk("nom_wr_cnt", 64'(wa_q.size() - w), 64'd8);
    chk_pixels("nom", w, 8'h10, 8);
    chk("nom_done_cnt", 64'(done_n - d), 64'd1);
    chk("nom_done_wen", 64'(done_wen), 64'd1);
    chk("nom_done_addr", 64'(done_addr), 64'd7);
    chk("nom_bank_at_done", 64'(done_bsel), 64'd0);
    chk("nom_bank_after", 64'(buf_sel), 64'd1);
    chk("nom_busy_end", 64'(busy), 64'd0);
    chk("nom_err_cnt", 64'(err_n - e), 64'd0);

    // Marker hunting
    f = fwd_q.size(); w = wa_q.size(); c = clr_n; d = done_n;
    send_byte(8'h00);
    chk("hunt_busy_00", 64'(busy), 64'd0);
    send_byte(8'hA5);
    chk("hunt_busy_a5", 64'(busy), 64'd1);
    send_byte(8'h00);
    chk("hunt_busy_drop", 64'(busy), 64'd0);
    send_byte(8'hA5);
    send_byte(8'hA5);
    chk("hunt_busy_a5a5", 64'(busy), 64'd1);
    chk("hunt_no_clr_yet", 64'(clr_n - c), 64'd0);
    send_byte(8'h5A);
    send_payload(8'h40, 24);
    idle(10);
    chk("hunt_clr_cnt", 64'(clr_n - c), 64'd1);
    chk("hunt_fwd_cnt", 64'(fwd_q.size() - f), 64'd24);
    chk("hunt_first_fwd", 64'(fwd_q[f]), 64'h40);
    chk_pixels("hunt", w, 8'h40, 8);
    chk("hunt_done_cnt", 64'(done_n - d), 64'd1);
    chk("hunt_bank_after", 64'(buf_sel), 64'd0);

    // Overrun: 30 bytes into a 24-byte frame
    f = fwd_q.size(); w = wa_q.size(); d = done_n;
    send_frame(8'h80, 30);
    idle(10);
    chk("ovr_fwd_cnt", 64'(fwd_q.size() - f), 64'd24);
    chk_fwd("ovr", f, 8'h80, 24);
    chk("ovr_wr_cnt", 64'(wa_q.size() - w), 64'd8);
    chk("ovr_done_cnt", 64'(done_n - d), 64'd1);
    chk("ovr_bank_after", 64'(buf_sel), 64'd1);

    f = fwd_q.size(); w = wa_q.size(); d = done_n;
    send_frame(8'hC0, 24);
    idle(10);
    chk("next_wr_cnt", 64'(wa_q.size() - w), 64'd8);
    chk_pixels("next", w, 8'hC0, 8);
    chk("next_bank_at_done", 64'(done_bsel), 64'd1);
    chk("next_bank_after", 64'(buf_sel), 64'd0);

    // Timeout after 10 payload bytes
    w = wa_q.size(); c = clr_n; d = done_n; e = err_n;
    send_frame(8'h20, 10);
    chk("tmo_busy_mid", 64'(busy), 64'd1);
    idle(30);
    chk("tmo_err_cnt", 64'(err_n - e), 64'd1);
    chk("tmo_err_delay", 64'(err_cyc - last_fwd_cyc), 64'd16);
    chk("tmo_busy_end", 64'(busy), 64'd0);
    chk("tmo_bank", 64'(buf_sel), 64'd0);
    chk("tmo_done_cnt", 64'(done_n - d), 64'd0);
    chk("tmo_wr_cnt", 64'(wa_q.size() - w), 64'd3);

    w = wa_q.size(); c = clr_n; d = done_n;
    send_frame(8'h60, 24);
    idle(10);
    chk("retry_clr_cnt", 64'(clr_n - c), 64'd1);
    chk("retry_wr_cnt", 64'(wa_q.size() - w), 64'd8);
    chk_pixels("retry", w, 8'h60, 8);
    chk("retry_done_cnt", 64'(done_n - d), 64'd1);
    chk("retry_bank_after", 64'(buf_sel), 64'd1);

    // Reset mid-frame after pixel 3
    w = wa_q.size(); d = done_n; e = err_n;
    send_frame(8'h30, 12);
    idle(4);
    chk("mid_wr_cnt", 64'(wa_q.size() - w), 64'd4);
    rst_n = 1'b0;
    idle(1);
    chk("mid_reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    idle(20);
    chk("mid_done_cnt", 64'(done_n - d), 64'd0);
    chk("mid_err_cnt", 64'(err_n - e), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);

    w = wa_q.size(); d = done_n;
    send_frame(8'h70, 24);
    idle(10);
    chk("post_wr_cnt", 64'(wa_q.size() - w), 64'd8);
    chk_pixels("post", w, 8'h70, 8);
    chk("post_done_cnt", 64'(done_n - d), 64'd1);
    chk("post_bank_at_done", 64'(done_bsel), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
